// File: rtl/estacionamiento_pkg.sv
// Shared types and constants for the parking-gate front-end and occupancy counter.
package estacionamiento_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENT_A,
      ENT_AB,
      ENT_B,
      SAL_B,
      SAL_AB,
      SAL_A,
      WAIT_CLEAR
   } estado_e;

   // Filtered barrier pattern {a,b}, 1 = beam blocked.
   localparam logic [1:0] P_LIBRE = 2'b00;
   localparam logic [1:0] P_A     = 2'b10;
   localparam logic [1:0] P_AB    = 2'b11;
   localparam logic [1:0] P_B     = 2'b01;

   localparam int unsigned CUENTA_W = 8;

endpackage

// File: rtl/filtro_sensor.sv
// One barrier input: 2-flop synchronizer plus optional debounce filter.
// Debounce is compiled in with SENSOR_DEBOUNCE_EN.
module filtro_sensor #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sensor_i,
   output logic filt_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) sync_q <= '0;
      else         sync_q <= {sync_q[0], sensor_i};
   end

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("filtro_sensor: DEBOUNCE_CYCLES must be at least 1");
   end

`ifdef SENSOR_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   // Counter runs only while the synchronized bit disagrees; any agreement resets it.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = sync_q[1];
         else                                   cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt_o = filt_q;
`else
   assign filt_o = sync_q[1];
`endif

endmodule

// File: rtl/detector_sentido.sv
// Decodes the blocking order of the two gate barriers into entry/exit pulses.
// Optional sensor debounce is enabled with SENSOR_DEBOUNCE_EN.
module detector_sentido
   import estacionamiento_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_a,
   input  logic sensor_b,
   output logic auto_entra,
   output logic auto_sale,
   output logic ocupado,
   output logic error_seq
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
      $error("detector_sentido: TIMEOUT_CYCLES must be at least 2");
   end

   logic       a_f, b_f;
   logic [1:0] p;

   filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_a (
      .clk_i(clk), .reset_i(reset), .sensor_i(sensor_a), .filt_o(a_f)
   );

   filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_b (
      .clk_i(clk), .reset_i(reset), .sensor_i(sensor_b), .filt_o(b_f)
   );

   assign p = {a_f, b_f};

   estado_e       estado_q, estado_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          entra_q, entra_d, sale_q, sale_d, err_q, err_d;

   always_comb begin
      estado_d = estado_q;
      entra_d  = 1'b0;
      sale_d   = 1'b0;
      err_d    = 1'b0;
      tmo_d    = '0;

      unique case (estado_q)
         IDLE:
            if      (p == P_A)  estado_d = ENT_A;
            else if (p == P_B)  estado_d = SAL_B;
            else if (p == P_AB) begin estado_d = WAIT_CLEAR; err_d = 1'b1; end
         ENT_A:
            if      (p == P_AB)    estado_d = ENT_AB;
            else if (p == P_LIBRE) estado_d = IDLE;
            else if (p == P_B)     begin estado_d = WAIT_CLEAR; err_d = 1'b1; end
         ENT_AB:
            if      (p == P_B)     estado_d = ENT_B;
            else if (p == P_A)     estado_d = ENT_A;
            else if (p == P_LIBRE) begin estado_d = WAIT_CLEAR; err_d = 1'b1; end
         ENT_B:
            if      (p == P_LIBRE) begin estado_d = IDLE; entra_d = 1'b1; end
            else if (p == P_AB)    estado_d = ENT_AB;
            else if (p == P_A)     begin estado_d = WAIT_CLEAR; err_d = 1'b1; end
         SAL_B:
            if      (p == P_AB)    estado_d = SAL_AB;
            else if (p == P_LIBRE) estado_d = IDLE;
            else if (p == P_A)     begin estado_d = WAIT_CLEAR; err_d = 1'b1; end
         SAL_AB:
            if      (p == P_A)     estado_d = SAL_A;
            else if (p == P_B)     estado_d = SAL_B;
            else if (p == P_LIBRE) begin estado_d = WAIT_CLEAR; err_d = 1'b1; end
         SAL_A:
            if      (p == P_LIBRE) begin estado_d = IDLE; sale_d = 1'b1; end
            else if (p == P_AB)    estado_d = SAL_AB;
            else if (p == P_B)     begin estado_d = WAIT_CLEAR; err_d = 1'b1; end
         WAIT_CLEAR:
            if (p == P_LIBRE) estado_d = IDLE;
         default: estado_d = IDLE;
      endcase

      // Timeout only advances while parked in an ENT_*/SAL_* state.
      if (estado_d == estado_q && estado_q != IDLE && estado_q != WAIT_CLEAR) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            estado_d = WAIT_CLEAR;
            err_d    = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= IDLE;
         tmo_q    <= '0;
         entra_q  <= 1'b0;
         sale_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         tmo_q    <= tmo_d;
         entra_q  <= entra_d;
         sale_q   <= sale_d;
         err_q    <= err_d;
      end
   end

   assign auto_entra = entra_q;
   assign auto_sale  = sale_q;
   assign error_seq  = err_q;
   assign ocupado    = (estado_q != IDLE);

endmodule

// File: tb/tb_detector_sentido.sv
// Directed bench for detector_sentido with TIMEOUT_CYCLES=20, DEBOUNCE_CYCLES=4.
module tb_detector_sentido;

`ifdef SENSOR_DEBOUNCE_EN
   localparam int DEB = 4;
`else
   localparam int DEB = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sensor_a = 1'b0;
   logic sensor_b = 1'b0;
   logic auto_entra, auto_sale, ocupado, error_seq;

   int total = 0;
   int bad   = 0;

   detector_sentido #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
      .auto_entra(auto_entra), .auto_sale(auto_sale),
      .ocupado(ocupado), .error_seq(error_seq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor: counts and timestamps pulses, seen at the falling edge.
   int n_entra = 0, n_sale = 0, n_err = 0, n_multi = 0, n_rise = 0;
   int entra_cyc = -1, sale_cyc = -1, err_cyc = -1, fall_cyc = -1;
   logic occ_prev = 1'b0;
   always @(negedge clk) begin
      if (auto_entra === 1'b1) begin n_entra++; entra_cyc = cyc; end
      if (auto_sale  === 1'b1) begin n_sale++;  sale_cyc  = cyc; end
      if (error_seq  === 1'b1) begin n_err++;   err_cyc   = cyc; end
      if (int'(auto_entra) + int'(auto_sale) + int'(error_seq) > 1) n_multi++;
      if (ocupado === 1'b1 && occ_prev === 1'b0) n_rise++;
      if (ocupado === 1'b0 && occ_prev === 1'b1) fall_cyc = cyc;
      occ_prev = ocupado;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int t_mark;
   task automatic pins(input logic a, input logic b);
      @(negedge clk);
      sensor_a = a;
      sensor_b = b;
      t_mark   = cyc;
   endtask

   task automatic waitc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int b_entra, b_sale, b_err, b_rise, r;
   task automatic base();
      b_entra = n_entra; b_sale = n_sale; b_err = n_err; b_rise = n_rise;
   endtask

   initial begin
      // Reset state
      waitc(3);
      chk("rst_entra", auto_entra, 0);
      chk("rst_sale", auto_sale, 0);
      chk("rst_err", error_seq, 0);
      chk("rst_ocupado", ocupado, 0);
      @(negedge clk); reset = 1'b0;
      waitc(3);

      // Clean entry
      base();
      pins(1, 0); waitc(5);
      pins(1, 1); waitc(5);
      pins(0, 1); waitc(5);
      pins(0, 0); r = t_mark; waitc(12);
      chk("entry_count", n_entra - b_entra, 1);
      chk("entry_latency", entra_cyc, r + 3 + DEB);
      chk("entry_ocup_fall", fall_cyc, r + 3 + DEB);
      chk("entry_no_sale", n_sale - b_sale, 0);
      chk("entry_no_err", n_err - b_err, 0);

      // Clean exit
      base();
      pins(0, 1); waitc(5);
      pins(1, 1); waitc(5);
      pins(1, 0); waitc(5);
      pins(0, 0); r = t_mark; waitc(12);
      chk("exit_count", n_sale - b_sale, 1);
      chk("exit_latency", sale_cyc, r + 3 + DEB);
      chk("exit_no_entra", n_entra - b_entra, 0);
      chk("exit_no_err", n_err - b_err, 0);

      // Partial entry then back-out
      base();
      pins(1, 0); waitc(5);
      pins(1, 1); waitc(5);
      pins(1, 0); waitc(5);
      pins(0, 0); waitc(12);
      chk("backout_pulses", (n_entra - b_entra) + (n_sale - b_sale) + (n_err - b_err), 0);
      chk("backout_ocupado", ocupado, 0);
      chk("backout_was_busy", n_rise - b_rise, 1);

      // Illegal jump 10 -> 01
      base();
      pins(1, 0); waitc(5);
      pins(0, 1); waitc(8);
      chk("jump_err", n_err - b_err, 1);
      chk("jump_ocupado_hold", ocupado, 1);
      pins(0, 0); r = t_mark; waitc(12);
      chk("jump_ocup_fall", fall_cyc, r + 3 + DEB);
      chk("jump_err_once", n_err - b_err, 1);
      chk("jump_no_events", (n_entra - b_entra) + (n_sale - b_sale), 0);

      // 11 straight from IDLE
      base();
      pins(1, 1); r = t_mark; waitc(8);
      chk("idle11_err", n_err - b_err, 1);
      chk("idle11_err_time", err_cyc, r + 3 + DEB);
      chk("idle11_ocupado", ocupado, 1);
      pins(0, 0); waitc(12);
      chk("idle11_clear", ocupado, 0);

      // Timeout holding 11 in ENT_AB
      base();
      pins(1, 0); waitc(5);
      pins(1, 1); r = t_mark; waitc(15);
      chk("tmo_not_yet", n_err - b_err, 0);
      waitc(15);
      chk("tmo_err", n_err - b_err, 1);
      chk("tmo_err_time", err_cyc, r + 23 + DEB);
      chk("tmo_ocupado", ocupado, 1);
      pins(0, 0); waitc(12);
      chk("tmo_release_events", (n_entra - b_entra) + (n_sale - b_sale), 0);
      chk("tmo_release_ocupado", ocupado, 0);

      // Reset while in ENT_AB
      base();
      pins(1, 0); waitc(5);
      pins(1, 1); waitc(8);
      chk("midrst_busy", ocupado, 1);
      @(negedge clk);
      reset = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0;
      @(negedge clk);
      chk("midrst_entra", auto_entra, 0);
      chk("midrst_sale", auto_sale, 0);
      chk("midrst_err", error_seq, 0);
      chk("midrst_ocupado", ocupado, 0);
      waitc(2); reset = 1'b0; waitc(12);
      chk("midrst_no_events",
          (n_entra - b_entra) + (n_sale - b_sale) + (n_err - b_err), 0);
      chk("midrst_idle", ocupado, 0);

`ifdef SENSOR_DEBOUNCE_EN
      // Short glitches on sensor_a must be filtered out
      base();
      for (int g = 1; g <= 3; g++) begin
         pins(1, 0); waitc(g - 1);
         pins(0, 0); waitc(8);
      end
      chk("glitch_no_busy", n_rise - b_rise, 0);
      chk("glitch_no_events",
          (n_entra - b_entra) + (n_sale - b_sale) + (n_err - b_err), 0);
`endif

      chk("one_hot_events", n_multi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/detector_sentido.md
# detector_sentido

Front-end for the parking counter: samples the two optical barriers at the single gate and decodes the order in which they are blocked into vehicle direction. Outputs one-cycle `auto_entra` / `auto_sale` pulses that drive the counter's matching inputs. Also flags malformed or stalled sequences. It sits between the gate sensor pins and the occupancy counter.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a sensor change is accepted (only used with debounce compiled in).
- `TIMEOUT_CYCLES`, default 1000: cycles with no accepted pattern change, outside IDLE, before the sequence is aborted. Must be ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sensor_a`  in  1  outer barrier, 1 = beam blocked; asynchronous to `clk`.
- `sensor_b`  in  1  inner barrier, 1 = beam blocked; asynchronous to `clk`.
- `auto_entra`  out  1  one-cycle pulse: a complete entry sequence was seen.
- `auto_sale`  out  1  one-cycle pulse: a complete exit sequence was seen.
- `ocupado`  out  1  level; high whenever the FSM is not IDLE.
- `error_seq`  out  1  one-cycle pulse: illegal pattern jump or timeout.

## Operation
- Each sensor passes through a 2-flop synchronizer, then an optional debounce filter. This yields the filtered pattern P = {a,b}.
- FSM states: IDLE, ENT_A, ENT_AB, ENT_B, SAL_B, SAL_AB, SAL_A, WAIT_CLEAR.
- Entry path is 00→10→11→01→00. The transition ENT_B with P=00 returns to IDLE and pulses `auto_entra`.
- Exit path is 00→01→11→10→00. The transition SAL_A with P=00 returns to IDLE and pulses `auto_sale`.
- From IDLE: P=10 goes to ENT_A; P=01 goes to SAL_B; P=11 goes to WAIT_CLEAR and pulses `error_seq`.
- Reversal: a pattern equal to the previous step's pattern moves back one state, with no pulse. Example: ENT_AB with P=10 goes to ENT_A.
- Backing out: ENT_A with P=00, or SAL_B with P=00, goes to IDLE with no pulse and no error.
- Any other pattern, e.g. ENT_A with P=01, goes to WAIT_CLEAR and pulses `error_seq`.
- WAIT_CLEAR stays until P=00, then goes to IDLE, with no pulse.
- Timeout counter:
  - Clears on every accepted state change and whenever in IDLE or WAIT_CLEAR.
  - Reaching TIMEOUT_CYCLES in any ENT_*/SAL_* state forces WAIT_CLEAR and pulses `error_seq`.
- At most one of `auto_entra`, `auto_sale`, `error_seq` is high in any cycle.
- The block does not know whether the lot is full or empty. Those boundaries are enforced by the downstream counter.

## Timing
- Reset values:
  - FSM = IDLE; synchronizers, filtered pattern and all counters = 0.
  - `auto_entra`, `auto_sale`, `error_seq`, `ocupado` = 0 in the cycle after the reset edge.
- `ocupado` is decoded from the registered state, with no added delay.
- Pin-to-P latency: 2 edges without debounce; 2 + DEBOUNCE_CYCLES edges with debounce.
- Event pulses are registered. Each is high for exactly one cycle, starting at the edge after P first shows the completing pattern.
- End-to-end, no debounce: final pin release to `auto_entra`/`auto_sale` rising = 3 edges.
- Reset mid-sequence:
  - The partial sequence is discarded and no pulse is emitted.
  - If beams are still blocked, the FSM follows the IDLE rules, e.g. 11 leads to an error followed by WAIT_CLEAR.
- Timeout is counted in filtered-domain cycles. The `error_seq` pulse appears at the edge when the counter reaches TIMEOUT_CYCLES.

## Configuration
- `SENSOR_DEBOUNCE_EN` defined:
  - Each filter keeps a counter per sensor.
  - The filtered bit takes the synchronized value only after it has differed from the current filtered bit for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old value clears the counter.
- Not defined: the filtered bit equals the synchronizer output, and DEBOUNCE_CYCLES is ignored.

## Structure
- Package `estacionamiento_pkg` holds:
  - the FSM state enum typedef;
  - the 2-bit pattern constants (P_LIBRE=00, P_A=10, P_AB=11, P_B=01);
  - the shared count width used with the occupancy counter.
- Sub-module `filtro_sensor`: synchronizer plus optional debounce for one bit, instantiated once per sensor.
- FSM and timeout counter live in `detector_sentido`.

## Test plan
- No debounce: drive 00→10→11→01→00 with 5 cycles per step → exactly one `auto_entra` pulse, 3 edges after the last release; `ocupado` falls in the same cycle.
- Drive 00→01→11→10→00 → exactly one `auto_sale` pulse; `auto_entra` and `error_seq` stay 0 throughout.
- Partial entry, then back-out: 10→11→10→00 → no pulses, FSM returns to IDLE, `ocupado` drops to 0.
- Illegal jump 10→01 → one `error_seq` pulse and `ocupado` stays high; it drops 1 cycle after P=00 is reached in WAIT_CLEAR.
- TIMEOUT_CYCLES=20, hold 11 → `error_seq` pulses after 20 cycles; releasing to 00 gives no event pulse.
- With `SENSOR_DEBOUNCE_EN` and DEBOUNCE_CYCLES=4:
  - 1–3-cycle glitches on `sensor_a` produce no state change.
  - A clean entry completes with `auto_entra` at 3+4 edges after the final release.
  - Asserting `reset` in ENT_AB gives no pulse, and all outputs are 0 the next cycle.
